mac_accumulator: RTL

Accumulation stage of the MAC unit, directly downstream of the 8x8 Vedic multiplier. It takes the multiplier's unsigned 16-bit products through a valid/ready handshake and sums them into a wider accumulator. After N_TERMS products, or earlier when `in_last` is asserted, it presents the sum as one result word (for example, one neuron dot-product) and holds it until the consumer accepts it.

---
 rtl/mac_pkg.sv | 27 ++
 rtl/mac_sat_add.sv | 27 ++
 rtl/mac_accumulator.sv | 103 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulation stage: product width,
// accumulator FSM states and the count-width helper.
package mac_pkg;

  localparam int PROD_W = 16;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // Bits needed to hold a term count in the range 0..n_terms.
  function automatic int cnt_width(input int n_terms);
    int width;
    width = clog2(n_terms + 1);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// ACC_W-bit unsigned accumulate adder with carry-out overflow flag.
// Define MAC_ACC_SATURATE_EN to clamp the sum at all-ones on overflow instead of wrapping.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] full_sum;

  // One extra bit captures the carry out of the accumulator's MSB.
  assign full_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign ovf      = full_sum[ACC_W];

`ifdef MAC_ACC_SATURATE_EN
  // Once clamped, any further non-zero product overflows again and re-clamps.
  assign sum = ovf ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates unsigned 16-bit products into an ACC_W-bit sum and presents one result
// per N_TERMS products (or per in_last). Saturation option: MAC_ACC_SATURATE_EN.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter  int ACC_W   = 24,
  parameter  int N_TERMS = 9,
  localparam int CNT_W   = cnt_width(N_TERMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS);

  if (ACC_W < PROD_W) begin : g_acc_w_check
    $error("mac_accumulator: ACC_W must be at least PROD_W");
  end
  if (N_TERMS < 1) begin : g_n_terms_check
    $error("mac_accumulator: N_TERMS must be at least 1");
  end

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf;
  logic             add_ovf;
  logic             accept;
  logic             close;

  mac_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc  (acc),
    .prod (in_prod),
    .sum  (acc_sum),
    .ovf  (add_ovf)
  );

  // Ready is decoded from the state register only, so out_ready never reaches in_ready.
  assign in_ready = (state == ST_ACC);

  // NOTE: every always_comb output is fully assigned on each pass, so no latch is inferred.
  always_comb begin
    accept  = in_valid && in_ready;
    cnt_inc = cnt + CNT_W'(1);
    close   = accept && (in_last || (cnt_inc == CNT_LAST));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
            ovf <= ovf | add_ovf;
            // A last flag on the final term is a single close.
            if (close) begin
              out_acc   <= acc_sum;
              out_ovf   <= ovf | add_ovf;
              out_cnt   <= cnt_inc;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule
